// File: rtl/dispatch_scheduler.sv
// In-order, credit-based dispatch from the dispatch-queue head to the issue queues, with one registered output stage.
// Optional performance counters are enabled by defining DISPATCH_SCHED_PERF_EN.
module dispatch_scheduler #(
    parameter int DISPATCH_WIDTH = 2,
    parameter int NUM_IQ         = 3,
    parameter int IQ_DEPTH       = 8,
    parameter int IQ_SEL_W       = 2,
    parameter int DATA_W         = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush_i,
    input  logic [DISPATCH_WIDTH-1:0]          dq_valid_i,
    input  logic [DISPATCH_WIDTH*IQ_SEL_W-1:0] dq_iq_sel_i,
    input  logic [DISPATCH_WIDTH*DATA_W-1:0]   dq_data_i,
    output logic [DISPATCH_WIDTH-1:0]          dq_ready_o,
    input  logic [NUM_IQ*$clog2(DISPATCH_WIDTH+1)-1:0] iq_free_i,
    output logic [DISPATCH_WIDTH-1:0]          disp_valid_o,
    output logic [DISPATCH_WIDTH*IQ_SEL_W-1:0] disp_iq_sel_o,
    output logic [DISPATCH_WIDTH*DATA_W-1:0]   disp_data_o
`ifdef DISPATCH_SCHED_PERF_EN
    ,
    output logic [31:0]                        perf_stall_cnt_o,
    output logic [31:0]                        perf_disp_cnt_o
`endif
);

    localparam int CNT_W  = $clog2(DISPATCH_WIDTH + 1);
    localparam int FREE_W = CNT_W;
    localparam int CRED_W = $clog2(IQ_DEPTH + 1);
    localparam int SUM_W  = CRED_W + 1;

    logic [CRED_W-1:0]         credit     [NUM_IQ];
    logic [CRED_W-1:0]         credit_n   [NUM_IQ];
    logic [CNT_W-1:0]          acc_cnt    [NUM_IQ];
    logic [NUM_IQ-1:0]         over_release;
    logic [DISPATCH_WIDTH-1:0] accept;

    // Slot-ordered acceptance; each slot sees the credits already consumed by earlier slots.
    always_comb begin
        logic             chain;
        logic             has_credit;
        logic [IQ_SEL_W-1:0] sel;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        accept = '0;
        for (int q = 0; q < NUM_IQ; q++) acc_cnt[q] = '0;
        chain = !rst && !flush_i;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            sel        = dq_iq_sel_i[i*IQ_SEL_W +: IQ_SEL_W];
            has_credit = 1'b0;
            for (int q = 0; q < NUM_IQ; q++) begin
                if (int'(sel) == q && SUM_W'(credit[q]) > SUM_W'(acc_cnt[q])) has_credit = 1'b1;
            end
            chain     = chain && dq_valid_i[i] && (int'(sel) < NUM_IQ) && has_credit;
            accept[i] = chain;
            for (int q = 0; q < NUM_IQ; q++) begin
                if (chain && int'(sel) == q) acc_cnt[q] = acc_cnt[q] + CNT_W'(1);
            end
        end
    end

    assign dq_ready_o = accept;

    // Releases are added after this cycle's acceptance, so they only become usable next cycle.
    always_comb begin
        logic [SUM_W-1:0] sum;
        over_release = '0;
        for (int q = 0; q < NUM_IQ; q++) begin
            sum = SUM_W'(credit[q]) - SUM_W'(acc_cnt[q])
                + SUM_W'(iq_free_i[q*FREE_W +: FREE_W]);
            if (sum > SUM_W'(IQ_DEPTH)) begin
                over_release[q] = 1'b1;
                credit_n[q]     = CRED_W'(IQ_DEPTH);
            end else begin
                credit_n[q]     = sum[CRED_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst || flush_i) begin
            for (int q = 0; q < NUM_IQ; q++) credit[q] <= CRED_W'(IQ_DEPTH);
        end else begin
            assert (over_release == '0)
                else $error("dispatch_scheduler: issue-queue credit over-release %b", over_release);
            for (int q = 0; q < NUM_IQ; q++) credit[q] <= credit_n[q];
        end
    end

    // Target and payload hold when a slot is not accepted; only the valid bit tracks every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_valid_o  <= '0;
            disp_iq_sel_o <= '0;
            disp_data_o   <= '0;
        end else begin
            disp_valid_o <= accept;
            for (int i = 0; i < DISPATCH_WIDTH; i++) begin
                if (accept[i]) begin
                    disp_iq_sel_o[i*IQ_SEL_W +: IQ_SEL_W] <= dq_iq_sel_i[i*IQ_SEL_W +: IQ_SEL_W];
                    disp_data_o[i*DATA_W +: DATA_W]       <= dq_data_i[i*DATA_W +: DATA_W];
                end
            end
        end
    end

`ifdef DISPATCH_SCHED_PERF_EN
    logic [32:0] disp_sum;
    assign disp_sum = {1'b0, perf_disp_cnt_o} + 33'($countones(accept));

    // Counters saturate and survive flushes; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt_o <= '0;
            perf_disp_cnt_o  <= '0;
        end else begin
            if (dq_valid_i[0] && !accept[0] && !flush_i && perf_stall_cnt_o != 32'hFFFF_FFFF)
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            perf_disp_cnt_o <= disp_sum[32] ? 32'hFFFF_FFFF : disp_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Self-checking bench for dispatch_scheduler: directed scenarios then randomized traffic against a credit-count model.
// Perf counters are checked too when DISPATCH_SCHED_PERF_EN is defined.
module tb_dispatch_scheduler;

    localparam int DW    = 2;
    localparam int NQ    = 3;
    localparam int DEPTH = 8;
    localparam int SW    = 2;
    localparam int DAW   = 64;
    localparam int FW    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush_i;
    logic [DW-1:0]     dq_valid_i;
    logic [DW*SW-1:0]  dq_iq_sel_i;
    logic [DW*DAW-1:0] dq_data_i;
    logic [DW-1:0]     dq_ready_o;
    logic [NQ*FW-1:0]  iq_free_i;
    logic [DW-1:0]     disp_valid_o;
    logic [DW*SW-1:0]  disp_iq_sel_o;
    logic [DW*DAW-1:0] disp_data_o;
`ifdef DISPATCH_SCHED_PERF_EN
    logic [31:0]       perf_stall_cnt_o;
    logic [31:0]       perf_disp_cnt_o;
`endif

    dispatch_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .dq_valid_i    (dq_valid_i),
        .dq_iq_sel_i   (dq_iq_sel_i),
        .dq_data_i     (dq_data_i),
        .dq_ready_o    (dq_ready_o),
        .iq_free_i     (iq_free_i),
        .disp_valid_o  (disp_valid_o),
        .disp_iq_sel_o (disp_iq_sel_o),
        .disp_data_o   (disp_data_o)
`ifdef DISPATCH_SCHED_PERF_EN
        ,
        .perf_stall_cnt_o (perf_stall_cnt_o),
        .perf_disp_cnt_o  (perf_disp_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: free slots per issue queue plus the expected output registers.
    int                cred [NQ];
    logic [DW-1:0]     exp_dv;
    logic [DW*SW-1:0]  exp_sel;
    logic [DW*DAW-1:0] exp_data;
    longint            exp_stall;
    longint            exp_disp;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] model_accept(input logic [DW-1:0] valid,
                                                   input logic [DW*SW-1:0] selv,
                                                   input logic fl, input logic r);
        int               used [NQ];
        int               s;
        logic             go;
        logic [DW-1:0]    acc;
        logic [DW*SW-1:0] sv;
        sv  = selv;
        acc = '0;
        for (int q = 0; q < NQ; q++) used[q] = 0;
        go = !fl && !r;
        for (int i = 0; i < DW; i++) begin
            s = int'(sv[i*SW +: SW]);
            if (go && valid[i] && s < NQ) begin
                go = (cred[s] - used[s]) > 0;
            end else begin
                go = 1'b0;
            end
            acc[i] = go;
            if (go) used[s]++;
        end
        return acc;
    endfunction

    function automatic int acc_to_q(input logic [DW-1:0] acc, input logic [DW*SW-1:0] selv, input int q);
        int n = 0;
        logic [DW*SW-1:0] sv;
        sv = selv;
        for (int i = 0; i < DW; i++) if (acc[i] && int'(sv[i*SW +: SW]) == q) n++;
        return n;
    endfunction

    function automatic logic [DW*DAW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: drive, check ready combinationally, advance the model at the edge, check outputs.
    task automatic cycle(input logic [DW-1:0] valid, input logic [DW*SW-1:0] selv,
                         input logic [DW*DAW-1:0] datav, input logic [NQ*FW-1:0] freev,
                         input logic fl, input logic r);
        logic [DW-1:0] acc;
        logic [NQ*FW-1:0] fv;
        int n;
        rst = r; flush_i = fl; dq_valid_i = valid; dq_iq_sel_i = selv;
        dq_data_i = datav; iq_free_i = freev;
        fv = freev;
        #1;
        acc = model_accept(valid, selv, fl, r);
        check("dq_ready", 128'(dq_ready_o), 128'(acc));
        @(posedge clk);
        if (r) begin
            for (int q = 0; q < NQ; q++) cred[q] = DEPTH;
            exp_dv = '0; exp_sel = '0; exp_data = '0;
            exp_stall = 0; exp_disp = 0;
        end else begin
            if (!fl && valid[0] && !acc[0] && exp_stall < 64'hFFFF_FFFF) exp_stall++;
            exp_disp += $countones(acc);
            if (exp_disp > 64'hFFFF_FFFF) exp_disp = 64'hFFFF_FFFF;
            for (int q = 0; q < NQ; q++) begin
                if (fl) begin
                    cred[q] = DEPTH;
                end else begin
                    n = cred[q] - acc_to_q(acc, selv, q) + int'(fv[q*FW +: FW]);
                    cred[q] = (n > DEPTH) ? DEPTH : n;
                end
            end
            exp_dv = acc;
            for (int i = 0; i < DW; i++) begin
                if (acc[i]) begin
                    exp_sel[i*SW +: SW]    = selv[i*SW +: SW];
                    exp_data[i*DAW +: DAW] = datav[i*DAW +: DAW];
                end
            end
        end
        #1;
        check("disp_valid", 128'(disp_valid_o), 128'(exp_dv));
        check("disp_sel", 128'(disp_iq_sel_o), 128'(exp_sel));
        check("disp_data", 128'(disp_data_o), 128'(exp_data));
`ifdef DISPATCH_SCHED_PERF_EN
        check("perf_stall", 128'(perf_stall_cnt_o), 128'(exp_stall));
        check("perf_disp", 128'(perf_disp_cnt_o), 128'(exp_disp));
`endif
    endtask

    initial begin
        logic [DW-1:0]    rv, ra;
        logic [DW*SW-1:0] rs;
        logic [NQ*FW-1:0] rf;
        logic             rfl, rr;
        int               bound;

        for (int q = 0; q < NQ; q++) cred[q] = DEPTH;
        exp_dv = '0; exp_sel = '0; exp_data = '0; exp_stall = 0; exp_disp = 0;

        // Reset holds ready low even with valid entries present
        cycle(2'b11, {2'd1, 2'd0}, rnd_data(), '0, 1'b0, 1'b1);
        cycle(2'b11, {2'd1, 2'd0}, rnd_data(), '0, 1'b1, 1'b1);
        // Two entries to different queues dispatch together
        cycle(2'b11, {2'd1, 2'd0}, rnd_data(), '0, 1'b0, 1'b0);
        check("cred_after_first", 128'({cred[2], cred[1], cred[0]}), 128'({32'd8, 32'd7, 32'd7}));
        cycle(2'b00, '0, rnd_data(), '0, 1'b0, 1'b0);

        // Exhaust IQ0, stall, then release one credit
        cycle(2'b00, '0, '0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) cycle(2'b11, {2'd0, 2'd0}, rnd_data(), '0, 1'b0, 1'b0);
        cycle(2'b01, {2'd0, 2'd0}, rnd_data(), '0, 1'b0, 1'b0);
        cycle(2'b01, {2'd0, 2'd0}, rnd_data(), 6'b00_00_01, 1'b0, 1'b0);
        cycle(2'b01, {2'd0, 2'd0}, rnd_data(), '0, 1'b0, 1'b0);

        // Single remaining credit admits only slot 0
        cycle(2'b00, '0, rnd_data(), 6'b00_00_01, 1'b0, 1'b0);
        cycle(2'b11, {2'd0, 2'd0}, rnd_data(), '0, 1'b0, 1'b0);

        // In-order blocking, bad target, non-contiguous valid
        cycle(2'b11, {2'd2, 2'd0}, rnd_data(), '0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cycle(2'b11, {2'd2, 2'd3}, rnd_data(), '0, 1'b0, 1'b0);
        cycle(2'b10, {2'd2, 2'd2}, rnd_data(), '0, 1'b0, 1'b0);
        cycle(2'b11, {2'd1, 2'd2}, rnd_data(), '0, 1'b0, 1'b0);

        // Same-cycle accept and release on IQ1 at one credit
        cycle(2'b00, '0, '0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) cycle(2'b11, {2'd1, 2'd1}, rnd_data(), '0, 1'b0, 1'b0);
        cycle(2'b01, {2'd1, 2'd1}, rnd_data(), '0, 1'b0, 1'b0);
        cycle(2'b01, {2'd1, 2'd1}, rnd_data(), 6'b00_01_00, 1'b0, 1'b0);
        cycle(2'b11, {2'd1, 2'd1}, rnd_data(), '0, 1'b0, 1'b0);

        // Flush restores all credits and kills the output stage; release during flush is ignored
        cycle(2'b11, {2'd0, 2'd2}, rnd_data(), 6'b00_01_00, 1'b1, 1'b0);
        check("cred_after_flush", 128'({cred[2], cred[1], cred[0]}), 128'({32'd8, 32'd8, 32'd8}));
        for (int k = 0; k < 5; k++) cycle(2'b11, {2'd1, 2'd1}, rnd_data(), '0, 1'b0, 1'b0);
        // Reset mid-stream discards the registered dispatch
        cycle(2'b11, {2'd0, 2'd2}, rnd_data(), '0, 1'b0, 1'b0);
        cycle(2'b11, {2'd0, 2'd2}, rnd_data(), '0, 1'b0, 1'b1);

        // Randomized traffic with legal releases only
        for (int k = 0; k < 600; k++) begin
            rv  = 2'($urandom_range(0, 3));
            rs  = 4'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (rs[1:0] == 2'd3) rs[1:0] = 2'($urandom_range(0, 2));
                if (rs[3:2] == 2'd3) rs[3:2] = 2'($urandom_range(0, 2));
            end
            rfl = ($urandom_range(0, 29) == 0);
            rr  = ($urandom_range(0, 99) == 0);
            ra  = model_accept(rv, rs, rfl, rr);
            rf  = '0;
            for (int q = 0; q < NQ; q++) begin
                bound = DEPTH - cred[q] + acc_to_q(ra, rs, q);
                if (bound > 3) bound = 3;
                if ($urandom_range(0, 2) == 0) rf[q*FW +: FW] = 2'($urandom_range(0, bound));
            end
            cycle(rv, rs, rnd_data(), rf, rfl, rr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
